io_handshake_unit: RTL and testbench



---
 rtl/io_pkg.sv | 20 ++
 rtl/bin2bcd_seq.sv | 56 +++++
 rtl/io_handshake_unit.sv | 121 ++++++++++++
 tb/tb_io_handshake_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the CPU I/O handshake stage: command codes, FSM states
// and the BCD digit adjust helper used by the sequential converter.
package io_pkg;
    localparam logic [1:0] IO_NONE = 2'b00;
    localparam logic [1:0] IO_IN   = 2'b01;
    localparam logic [1:0] IO_OUT  = 2'b10;
    localparam int         BCD_MAX = 999;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IN_WAIT,
        ST_IN_DONE,
        ST_OUT_CONV,
        ST_OUT_DONE
    } state_e;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary to BCD converter, one bit per cycle.
// done_o and the digit outputs reflect the result of the final iteration combinationally.
module bin2bcd_seq
    import io_pkg::*;
#(
    parameter int CONV_BITS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [CONV_BITS-1:0] value_i,
    output logic                 done_o,
    output logic [3:0]           ones_o,
    output logic [3:0]           tens_o,
    output logic [3:0]           hund_o
);
    localparam int CNT_W = $clog2(CONV_BITS + 1);

    logic                 busy_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CONV_BITS-1:0] bin_q, bin_d;
    logic [11:0]          bcd_q, bcd_d, bcd_adj;
    logic                 last;

    always_comb begin
        bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
        bcd_d   = {bcd_adj[10:0], bin_q[CONV_BITS-1]};
        bin_d   = bin_q << 1;
        last    = busy_q && (cnt_q == CNT_W'(CONV_BITS - 1));
    end

    // Expose the post-iteration value so the caller can latch it on the last cycle.
    assign done_o = last;
    assign ones_o = bcd_d[3:0];
    assign tens_o = bcd_d[7:4];
    assign hund_o = bcd_d[11:8];

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            bin_q  <= '0;
            bcd_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            bin_q  <= value_i;
            bcd_q  <= '0;
        end else if (busy_q) begin
            bcd_q <= bcd_d;
            bin_q <= bin_d;
            cnt_q <= cnt_q + 1'b1;
            if (last) busy_q <= 1'b0;
        end
    end
endmodule

// File: rtl/io_handshake_unit.sv
// CPU I/O stage: IN waits for a button press and returns the switches, OUT converts
// a word to three held BCD digits. parada stalls the PC while a command runs.
module io_handshake_unit
    import io_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int IN_W      = 4,
    parameter int CONV_BITS = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        io_ctrl,
    input  logic [DATA_W-1:0] dado_out,
    input  logic              botao_in,
    input  logic [IN_W-1:0]   entrada_dados,
    output logic [DATA_W-1:0] dado_lido,
    output logic              dado_valido,
    output logic              parada,
    output logic [3:0]        unidade,
    output logic [3:0]        dezena,
    output logic [3:0]        centena,
    output logic              overflow
);
    state_e            state_q, state_d;
    logic              btn_q, rise;
    logic [DATA_W-1:0] op_q, op_d;
    logic [DATA_W-1:0] lido_q, lido_d;
    logic [3:0]        uni_q, uni_d, dez_q, dez_d, cen_q, cen_d;
    logic              ovf_q, ovf_d;
    logic              conv_start, conv_done;
    logic [3:0]        conv_uni, conv_dez, conv_cen;

    bin2bcd_seq #(.CONV_BITS(CONV_BITS)) u_conv (
        .clk     (clk),
        .reset   (reset),
        .start_i (conv_start),
        .value_i (dado_out[CONV_BITS-1:0]),
        .done_o  (conv_done),
        .ones_o  (conv_uni),
        .tens_o  (conv_dez),
        .hund_o  (conv_cen)
    );

    assign rise = botao_in & ~btn_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        lido_d     = lido_q;
        uni_d      = uni_q;
        dez_d      = dez_q;
        cen_d      = cen_q;
        ovf_d      = ovf_q;
        parada     = 1'b0;
        conv_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (io_ctrl == IO_IN) begin
                    parada  = 1'b1;
                    state_d = ST_IN_WAIT;
                end else if (io_ctrl == IO_OUT) begin
                    parada     = 1'b1;
                    conv_start = 1'b1;
                    op_d       = dado_out;
                    state_d    = ST_OUT_CONV;
                end
            end
            ST_IN_WAIT: begin
                parada = 1'b1;
                if (rise) begin
                    lido_d  = {{(DATA_W-IN_W){1'b0}}, entrada_dados};
                    state_d = ST_IN_DONE;
                end
            end
            ST_OUT_CONV: begin
                parada = 1'b1;
                // Digits load on the last iteration so they are visible during OUT_DONE.
                if (conv_done) begin
                    if (op_q > DATA_W'(BCD_MAX)) begin
                        {cen_d, dez_d, uni_d} = {4'd9, 4'd9, 4'd9};
                        ovf_d = 1'b1;
                    end else begin
                        {cen_d, dez_d, uni_d} = {conv_cen, conv_dez, conv_uni};
                        ovf_d = 1'b0;
                    end
                    state_d = ST_OUT_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            btn_q   <= 1'b0;
            op_q    <= '0;
            lido_q  <= '0;
            uni_q   <= '0;
            dez_q   <= '0;
            cen_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            btn_q   <= botao_in;
            op_q    <= op_d;
            lido_q  <= lido_d;
            uni_q   <= uni_d;
            dez_q   <= dez_d;
            cen_q   <= cen_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dado_lido   = lido_q;
    assign dado_valido = (state_q == ST_IN_DONE);
    assign unidade     = uni_q;
    assign dezena      = dez_q;
    assign centena     = cen_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_io_handshake_unit.sv
// Directed bench for io_handshake_unit: reset, OUT conversions, IN capture and button edge rules.
module tb_io_handshake_unit;
    import io_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  io_ctrl;
    logic [31:0] dado_out;
    logic        botao_in;
    logic [3:0]  entrada_dados;
    logic [31:0] dado_lido;
    logic        dado_valido, parada, overflow;
    logic [3:0]  unidade, dezena, centena;

    int tests = 0;
    int fails = 0;
    int stall;

    io_handshake_unit dut (
        .clk(clk), .reset(reset), .io_ctrl(io_ctrl), .dado_out(dado_out),
        .botao_in(botao_in), .entrada_dados(entrada_dados), .dado_lido(dado_lido),
        .dado_valido(dado_valido), .parada(parada), .unidade(unidade),
        .dezena(dezena), .centena(centena), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are checked 2 units after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue OUT v from IDLE; counts stall cycles (bounded) and checks the old digit is held mid-conversion.
    task automatic run_out(input logic [31:0] v, input logic [3:0] old_uni, output int n);
        io_ctrl  = IO_OUT;
        dado_out = v;
        #1;
        n = 0;
        while (parada && n < 30) begin
            n++;
            if (n == 6) chk("hold_during_conv", {28'd0, unidade}, {28'd0, old_uni});
            tick();
            io_ctrl  = IO_NONE;
            dado_out = 32'hDEAD_BEEF;
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; io_ctrl = IO_OUT; dado_out = 32'd5; botao_in = 1'b0; entrada_dados = 4'h0;
        repeat (3) tick();
        reset = 1'b0; io_ctrl = IO_NONE;
        #1;
        chk("rst_parada", {31'd0, parada}, 32'd0);
        chk("rst_lido", dado_lido, 32'd0);
        chk("rst_valido", {31'd0, dado_valido}, 32'd0);
        chk("rst_digits", {20'd0, centena, dezena, unidade}, 32'h000);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        tick(); #1;
        chk("rst_digits_hold", {20'd0, centena, dezena, unidade}, 32'h000);

        // OUT 123
        run_out(32'd123, 4'd0, stall);
        chk("out123_stall", stall, 32'd11);
        chk("out123_digits", {20'd0, centena, dezena, unidade}, 32'h123);
        chk("out123_ovf", {31'd0, overflow}, 32'd0);
        tick(); #1;

        // OUT 1000 clamps, then OUT 42
        run_out(32'd1000, 4'd3, stall);
        chk("out1000_stall", stall, 32'd11);
        chk("out1000_digits", {20'd0, centena, dezena, unidade}, 32'h999);
        chk("out1000_ovf", {31'd0, overflow}, 32'd1);
        tick(); #1;
        run_out(32'd42, 4'd9, stall);
        chk("out42_digits", {20'd0, centena, dezena, unidade}, 32'h042);
        chk("out42_ovf", {31'd0, overflow}, 32'd0);
        tick(); #1;

        // IN with press after 20 cycles
        entrada_dados = 4'hA; io_ctrl = IO_IN;
        #1;
        chk("in_accept_parada", {31'd0, parada}, 32'd1);
        stall = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            io_ctrl = IO_OUT;  // ignored while waiting
            #1;
            if (parada) stall++;
        end
        chk("in_wait_parada", stall, 32'd20);
        chk("in_wait_valido", {31'd0, dado_valido}, 32'd0);
        botao_in = 1'b1; io_ctrl = IO_NONE;
        tick();
        entrada_dados = 4'h5;
        #1;
        chk("in_lido", dado_lido, 32'h0000_000A);
        chk("in_valido", {31'd0, dado_valido}, 32'd1);
        chk("in_done_parada", {31'd0, parada}, 32'd0);
        tick(); #1;
        chk("in_valido_drop", {31'd0, dado_valido}, 32'd0);
        chk("in_digits_untouched", {20'd0, centena, dezena, unidade}, 32'h042);

        // Button held high from before the IN: no capture until release and re-press
        botao_in = 1'b0;
        tick();
        botao_in = 1'b1;
        tick();
        entrada_dados = 4'h3; io_ctrl = IO_IN;
        tick();
        io_ctrl = IO_NONE;
        repeat (4) tick();
        #1;
        chk("held_no_capture_parada", {31'd0, parada}, 32'd1);
        chk("held_no_capture_valido", {31'd0, dado_valido}, 32'd0);
        botao_in = 1'b0;
        tick(); #1;
        chk("release_parada", {31'd0, parada}, 32'd1);
        botao_in = 1'b1;
        tick(); #1;
        chk("repress_lido", dado_lido, 32'h0000_0003);
        chk("repress_valido", {31'd0, dado_valido}, 32'd1);
        botao_in = 1'b0;
        tick(); #1;

        // OUT 456 aborted by reset during iteration 5
        io_ctrl = IO_OUT; dado_out = 32'd456;
        tick();
        io_ctrl = IO_NONE;
        repeat (4) tick();
        #1;
        chk("abort_parada_mid", {31'd0, parada}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("abort_parada", {31'd0, parada}, 32'd0);
        chk("abort_digits", {20'd0, centena, dezena, unidade}, 32'h000);
        chk("abort_lido", dado_lido, 32'd0);
        tick(); #1;
        chk("abort_stays_idle", {31'd0, parada}, 32'd0);

        run_out(32'd7, 4'd0, stall);
        chk("out7_stall", stall, 32'd11);
        chk("out7_digits", {20'd0, centena, dezena, unidade}, 32'h007);
        tick();

        io_ctrl = 2'b11;
        #1;
        chk("cmd11_parada", {31'd0, parada}, 32'd0);
        tick(); #1;
        chk("cmd11_parada_next", {31'd0, parada}, 32'd0);
        chk("cmd11_digits_hold", {20'd0, centena, dezena, unidade}, 32'h007);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
